mem_bus_router: RTL and testbench

//  Parametrised memory-bus router between the Vicuna/Ibex data port and N_SLV peripheral slaves (timer, GPIO, UART, SRAM, ...).

---
 rtl/mem_bus_router_if.sv | 25 ++
 rtl/mem_bus_router.sv | 195 +++++++++++++++++++
 tb/tb_mem_bus_router.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_router_if.sv
// Host-side memory bus between the core data port and mem_bus_router.
// master: the core (drives requests); slave: the router (grants and responds).
interface mem_bus_router_if #(
    parameter int unsigned MEM_W = 32
);
    logic               host_req_i;
    logic               host_gnt_o;
    logic [31:0]        host_addr_i;
    logic               host_we_i;
    logic [MEM_W/8-1:0] host_be_i;
    logic [MEM_W-1:0]   host_wdata_i;
    logic               host_rvalid_o;
    logic               host_err_o;
    logic [MEM_W-1:0]   host_rdata_o;

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o
    );

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o
    );
endinterface

// File: rtl/mem_bus_router.sv
// Memory-bus router: decodes host requests onto N_SLV slaves by base/mask region, tracks
// outstanding transactions in an order FIFO and returns responses strictly in request order.
// Unmapped addresses are served by an internal error slave (ID = N_SLV).
// Optional feature macro: MEM_ROUTER_ERR_CAPTURE_EN adds a sticky first-error address capture.
module mem_bus_router #(
    parameter int unsigned         MEM_W       = 32,
    parameter int unsigned         N_SLV       = 4,
    parameter int unsigned         MAX_OUTST   = 2,
    parameter logic [32*N_SLV-1:0] REGION_BASE = {32'h8000_0000, 32'h0000_0100,
                                                  32'h0000_0010, 32'h0000_0010},
    parameter logic [32*N_SLV-1:0] REGION_MASK = {32'h8000_0000, 32'hFFFF_FF00,
                                                  32'hFFFF_FFF0, 32'hFFFF_FFFF}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_bus_router_if.slave          host,
    output logic [N_SLV-1:0]         slv_req_o,
    input  logic [N_SLV-1:0]         slv_gnt_i,
    output logic [31:0]              slv_addr_o,
    output logic                     slv_we_o,
    output logic [MEM_W/8-1:0]       slv_be_o,
    output logic [MEM_W-1:0]         slv_wdata_o,
    input  logic [N_SLV-1:0]         slv_rvalid_i,
    input  logic [N_SLV-1:0]         slv_err_i,
    input  logic [N_SLV*MEM_W-1:0]   slv_rdata_i
`ifdef MEM_ROUTER_ERR_CAPTURE_EN
    ,
    output logic                     err_valid_o,
    output logic [31:0]              err_addr_o,
    input  logic                     err_clr_i
`endif
);
    localparam int unsigned IdW  = $clog2(N_SLV + 1);
    localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    localparam logic [IdW-1:0]  ErrId  = IdW'(N_SLV);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTST);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(MAX_OUTST - 1);

    typedef enum logic [1:0] {StEmpty, StActive, StFull} fifo_state_e;

    fifo_state_e      r_state;
    fifo_state_e      w_state_next;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_next;
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [IdW-1:0]   r_fifo [MAX_OUTST];

    logic [IdW-1:0]   w_id;
    logic             w_hit;
    logic             w_full;
    logic             w_empty;
    logic [N_SLV-1:0] w_slv_req;
    logic             w_slv_gnt;
    logic             w_gnt;
    logic [IdW-1:0]   w_head;
    logic             w_rvalid;
    logic             w_err;
    logic [MEM_W-1:0] w_rdata;
    logic             w_push;
    logic             w_pop;

    // Address decode: iterate high-to-low so the lowest matching index wins.
    always_comb begin
        w_id = ErrId;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((host.host_addr_i & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32]) begin
                w_id = IdW'(i);
            end
        end
    end

    assign w_hit   = (w_id != ErrId);
    assign w_full  = (r_state == StFull);
    assign w_empty = (r_state == StEmpty);

    // Request forwarding: only the decoded slave sees req, and nothing is forwarded while full.
    always_comb begin
        w_slv_req = '0;
        w_slv_gnt = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (w_id == IdW'(i)) begin
                w_slv_req[i] = host.host_req_i & ~w_full;
                w_slv_gnt    = slv_gnt_i[i];
            end
        end
        // The error slave grants in zero cycles.
        w_gnt = host.host_req_i & ~w_full & (w_hit ? w_slv_gnt : 1'b1);
    end

    assign w_head = r_fifo[r_rptr];

    // Response return: only the slave at the FIFO head can complete; others are dropped.
    always_comb begin
        w_rvalid = 1'b0;
        w_err    = 1'b0;
        w_rdata  = '0;
        if (!w_empty) begin
            if (w_head == ErrId) begin
                w_rvalid = 1'b1;
                w_err    = 1'b1;
            end else begin
                for (int i = 0; i < N_SLV; i++) begin
                    if (w_head == IdW'(i)) begin
                        w_rvalid = slv_rvalid_i[i];
                        w_err    = slv_rvalid_i[i] & slv_err_i[i];
                        if (slv_rvalid_i[i] && !slv_err_i[i]) begin
                            w_rdata = slv_rdata_i[MEM_W*i +: MEM_W];
                        end
                    end
                end
            end
        end
    end

    assign w_push = w_gnt;
    assign w_pop  = w_rvalid;

    // Occupancy next-state; push and pop together leave the count unchanged.
    always_comb begin
        w_cnt_next = r_cnt;
        unique case ({w_push, w_pop})
            2'b10:   w_cnt_next = r_cnt + CntW'(1);
            2'b01:   w_cnt_next = r_cnt - CntW'(1);
            default: w_cnt_next = r_cnt;
        endcase
        if (w_cnt_next == '0) begin
            w_state_next = StEmpty;
        end else if (w_cnt_next == CntMax) begin
            w_state_next = StFull;
        end else begin
            w_state_next = StActive;
        end
    end

    // Order FIFO and its EMPTY/ACTIVE/FULL state; pointers wrap at MAX_OUTST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StEmpty;
            r_cnt   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_push) begin
                r_fifo[r_wptr] <= w_id;
                r_wptr         <= (r_wptr == PtrMax) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrMax) ? '0 : r_rptr + PtrW'(1);
            end
        end
    end

    // Outputs are forced low while reset is asserted.
    assign host.host_gnt_o    = rst_n & w_gnt;
    assign host.host_rvalid_o = rst_n & w_rvalid;
    assign host.host_err_o    = rst_n & w_err;
    assign host.host_rdata_o  = rst_n ? w_rdata : '0;
    assign slv_req_o          = rst_n ? w_slv_req : '0;
    assign slv_addr_o         = rst_n ? host.host_addr_i : '0;
    assign slv_we_o           = rst_n & host.host_we_i;
    assign slv_be_o           = rst_n ? host.host_be_i : '0;
    assign slv_wdata_o        = rst_n ? host.host_wdata_i : '0;

`ifdef MEM_ROUTER_ERR_CAPTURE_EN
    logic        r_err_valid;
    logic [31:0] r_err_addr;
    logic        w_err_evt;

    assign w_err_evt = w_gnt & ~w_hit;

    // Sticky first-error capture; a capture in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
        end else if (w_err_evt && (!r_err_valid || err_clr_i)) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= host.host_addr_i;
        end else if (err_clr_i) begin
            r_err_valid <= 1'b0;
        end
    end

    assign err_valid_o = rst_n & r_err_valid;
    assign err_addr_o  = rst_n ? r_err_addr : '0;
`endif
endmodule

// File: tb/tb_mem_bus_router.sv
// Directed bench for mem_bus_router with the default 4-slave map
// (0x10 timer, 0x11-0x1F GPIO, 0x100-0x1FF UART, upper half SRAM).
module tb_mem_bus_router;
    localparam int unsigned MEM_W = 32;
    localparam int unsigned N_SLV = 4;

    logic                   clk;
    logic                   rst_n;
    logic [N_SLV-1:0]       slv_req;
    logic [N_SLV-1:0]       slv_gnt;
    logic [31:0]            slv_addr;
    logic                   slv_we;
    logic [MEM_W/8-1:0]     slv_be;
    logic [MEM_W-1:0]       slv_wdata;
    logic [N_SLV-1:0]       slv_rvalid;
    logic [N_SLV-1:0]       slv_err;
    logic [N_SLV*MEM_W-1:0] slv_rdata;
`ifdef MEM_ROUTER_ERR_CAPTURE_EN
    logic                   err_valid;
    logic [31:0]            err_addr;
    logic                   err_clr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_router_if #(.MEM_W(MEM_W)) bus ();

    mem_bus_router #(
        .MEM_W     (MEM_W),
        .N_SLV     (N_SLV),
        .MAX_OUTST (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (bus.slave),
        .slv_req_o    (slv_req),
        .slv_gnt_i    (slv_gnt),
        .slv_addr_o   (slv_addr),
        .slv_we_o     (slv_we),
        .slv_be_o     (slv_be),
        .slv_wdata_o  (slv_wdata),
        .slv_rvalid_i (slv_rvalid),
        .slv_err_i    (slv_err),
        .slv_rdata_i  (slv_rdata)
`ifdef MEM_ROUTER_ERR_CAPTURE_EN
        ,
        .err_valid_o  (err_valid),
        .err_addr_o   (err_addr),
        .err_clr_i    (err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic req(input logic v, input logic [31:0] a, input logic we);
        bus.host_req_i   = v;
        bus.host_addr_i  = a;
        bus.host_we_i    = we;
        bus.host_be_i    = 4'hF;
        bus.host_wdata_i = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req(1'b1, 32'h0000_0010, 1'b0);
        #12;
        n_tests++; if (bus.host_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", bus.host_gnt_o); end
        n_tests++; if (slv_req !== 4'b0000) begin n_fail++; $display("FAIL rst_slv_req: got %b want 0000", slv_req); end
        n_tests++; if (slv_addr !== 32'h0) begin n_fail++; $display("FAIL rst_slv_addr: got %h want 0", slv_addr); end
        req(1'b0, 32'h0, 1'b0);
        cyc(); rst_n = 1'b1; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", bus.host_rvalid_o); end
    endtask

    task automatic test_timer_read();
        cyc(); req(1'b1, 32'h0000_0010, 1'b0); #1;
        n_tests++; if (slv_req !== 4'b0001) begin n_fail++; $display("FAIL t1_slv_req: got %b want 0001", slv_req); end
        n_tests++; if (bus.host_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t1_gnt: got %b want 1", bus.host_gnt_o); end
        n_tests++; if (slv_addr !== 32'h10) begin n_fail++; $display("FAIL t1_slv_addr: got %h want 10", slv_addr); end
        cyc(); req(1'b0, 32'h0, 1'b0); #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t1_early_rvalid: got %b want 0", bus.host_rvalid_o); end
        cyc(); slv_rvalid = 4'b0001; slv_rdata[0 +: 32] = 32'h1; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL t1_rvalid: got %b want 1", bus.host_rvalid_o); end
        n_tests++; if (bus.host_rdata_o !== 32'h1) begin n_fail++; $display("FAIL t1_rdata: got %h want 1", bus.host_rdata_o); end
        n_tests++; if (bus.host_err_o !== 1'b0) begin n_fail++; $display("FAIL t1_err: got %b want 0", bus.host_err_o); end
        cyc(); slv_rvalid = 4'b0000; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t1_after: got %b want 0", bus.host_rvalid_o); end
    endtask

    task automatic test_unmapped();
        cyc(); req(1'b1, 32'h0000_0200, 1'b1); #1;
        n_tests++; if (bus.host_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t2_gnt: got %b want 1", bus.host_gnt_o); end
        n_tests++; if (slv_req !== 4'b0000) begin n_fail++; $display("FAIL t2_slv_req: got %b want 0000", slv_req); end
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t2_zero_lat: got %b want 0", bus.host_rvalid_o); end
        cyc(); req(1'b0, 32'h0, 1'b0); slv_rdata = '1; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL t2_rvalid: got %b want 1", bus.host_rvalid_o); end
        n_tests++; if (bus.host_err_o !== 1'b1) begin n_fail++; $display("FAIL t2_err: got %b want 1", bus.host_err_o); end
        n_tests++; if (bus.host_rdata_o !== 32'h0) begin n_fail++; $display("FAIL t2_rdata: got %h want 0", bus.host_rdata_o); end
        cyc(); slv_rdata = '0; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t2_after: got %b want 0", bus.host_rvalid_o); end
    endtask

    task automatic test_in_order();
        cyc(); req(1'b1, 32'h8000_0000, 1'b0); #1;
        n_tests++; if (slv_req !== 4'b1000) begin n_fail++; $display("FAIL t3_sram_req: got %b want 1000", slv_req); end
        cyc(); req(1'b1, 32'h0000_0014, 1'b0); #1;
        n_tests++; if (slv_req !== 4'b0010) begin n_fail++; $display("FAIL t3_gpio_req: got %b want 0010", slv_req); end
        n_tests++; if (bus.host_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t3_gpio_gnt: got %b want 1", bus.host_gnt_o); end
        cyc(); req(1'b0, 32'h0, 1'b0); slv_rvalid = 4'b0010; slv_rdata[32 +: 32] = 32'h6; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t3_gpio_early: got %b want 0", bus.host_rvalid_o); end
        cyc(); slv_rvalid = 4'b1010; slv_rdata[96 +: 32] = 32'hAAAA_5555; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL t3_sram_rvalid: got %b want 1", bus.host_rvalid_o); end
        n_tests++; if (bus.host_rdata_o !== 32'hAAAA_5555) begin n_fail++; $display("FAIL t3_sram_rdata: got %h want aaaa5555", bus.host_rdata_o); end
        cyc(); slv_rvalid = 4'b0010; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL t3_gpio_rvalid: got %b want 1", bus.host_rvalid_o); end
        n_tests++; if (bus.host_rdata_o !== 32'h6) begin n_fail++; $display("FAIL t3_gpio_rdata: got %h want 6", bus.host_rdata_o); end
        cyc(); slv_rvalid = 4'b0000; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t3_after: got %b want 0", bus.host_rvalid_o); end
    endtask

    task automatic test_back_to_back();
        cyc(); req(1'b1, 32'h8000_0004, 1'b0); #1;
        n_tests++; if (bus.host_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t4_gnt1: got %b want 1", bus.host_gnt_o); end
        cyc(); #1;
        n_tests++; if (bus.host_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t4_gnt2: got %b want 1", bus.host_gnt_o); end
        cyc(); #1;
        n_tests++; if (bus.host_gnt_o !== 1'b0) begin n_fail++; $display("FAIL t4_full_gnt: got %b want 0", bus.host_gnt_o); end
        n_tests++; if (slv_req !== 4'b0000) begin n_fail++; $display("FAIL t4_full_req: got %b want 0000", slv_req); end
        // Pop while full must still withhold the grant this cycle.
        cyc(); slv_rvalid = 4'b1000; slv_rdata[96 +: 32] = 32'h11; #1;
        n_tests++; if (bus.host_gnt_o !== 1'b0) begin n_fail++; $display("FAIL t4_pop_gnt: got %b want 0", bus.host_gnt_o); end
        n_tests++; if (bus.host_rdata_o !== 32'h11) begin n_fail++; $display("FAIL t4_rdata1: got %h want 11", bus.host_rdata_o); end
        cyc(); slv_rvalid = 4'b0000; #1;
        n_tests++; if (bus.host_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t4_gnt3: got %b want 1", bus.host_gnt_o); end
        n_tests++; if (slv_req !== 4'b1000) begin n_fail++; $display("FAIL t4_req3: got %b want 1000", slv_req); end
        cyc(); req(1'b0, 32'h0, 1'b0); slv_rvalid = 4'b1000; slv_rdata[96 +: 32] = 32'h22; #1;
        n_tests++; if (bus.host_rdata_o !== 32'h22) begin n_fail++; $display("FAIL t4_rdata2: got %h want 22", bus.host_rdata_o); end
        cyc(); slv_rdata[96 +: 32] = 32'h33; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL t4_rvalid3: got %b want 1", bus.host_rvalid_o); end
        n_tests++; if (bus.host_rdata_o !== 32'h33) begin n_fail++; $display("FAIL t4_rdata3: got %h want 33", bus.host_rdata_o); end
        cyc(); #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t4_drained: got %b want 0", bus.host_rvalid_o); end
        slv_rvalid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        cyc(); req(1'b1, 32'h8000_0008, 1'b0);
        cyc(); cyc(); req(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t5_in_rst: got %b want 0", bus.host_rvalid_o); end
        cyc(); rst_n = 1'b1; slv_rvalid = 4'b1000; slv_rdata[96 +: 32] = 32'h55; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t5_stale_rvalid: got %b want 0", bus.host_rvalid_o); end
        cyc(); slv_rvalid = 4'b0000; req(1'b1, 32'h0000_0010, 1'b0); #1;
        n_tests++; if (slv_req !== 4'b0001) begin n_fail++; $display("FAIL t5_req: got %b want 0001", slv_req); end
        n_tests++; if (bus.host_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t5_gnt: got %b want 1", bus.host_gnt_o); end
        cyc(); req(1'b0, 32'h0, 1'b0); slv_rvalid = 4'b0001; slv_rdata[0 +: 32] = 32'h77; #1;
        n_tests++; if (bus.host_rdata_o !== 32'h77) begin n_fail++; $display("FAIL t5_rdata: got %h want 77", bus.host_rdata_o); end
        cyc(); slv_rvalid = 4'b0000; #1;
        n_tests++; if (bus.host_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t5_after: got %b want 0", bus.host_rvalid_o); end
    endtask

`ifdef MEM_ROUTER_ERR_CAPTURE_EN
    task automatic test_err_capture();
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0; #1;
        n_tests++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL t6_cleared0: got %b want 0", err_valid); end
        req(1'b1, 32'h0000_0200, 1'b0);
        cyc(); req(1'b1, 32'h0000_0300, 1'b0); #1;
        n_tests++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL t6_valid: got %b want 1", err_valid); end
        n_tests++; if (err_addr !== 32'h200) begin n_fail++; $display("FAIL t6_addr: got %h want 200", err_addr); end
        cyc(); req(1'b0, 32'h0, 1'b0); #1;
        n_tests++; if (err_addr !== 32'h200) begin n_fail++; $display("FAIL t6_no_overwrite: got %h want 200", err_addr); end
        err_clr = 1'b1;
        cyc(); err_clr = 1'b0; #1;
        n_tests++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL t6_clear: got %b want 0", err_valid); end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        slv_gnt    = 4'b1111;
        slv_rvalid = 4'b0000;
        slv_err    = 4'b0000;
        slv_rdata  = '0;
`ifdef MEM_ROUTER_ERR_CAPTURE_EN
        err_clr    = 1'b0;
`endif
        test_reset();
        test_timer_read();
        test_unmapped();
        test_in_order();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_ROUTER_ERR_CAPTURE_EN
        test_err_capture();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
